bomb_map_writer: RTL and testbench
==================================

BOMB_MAP_WRITER -- requirements
Module: bomb_map_writer

Interface
REQ-001 Parameters SHALL be: NUM_ROW 11, map rows; NUM_COL 19, map columns; DATA_WIDTH 4, tile code width; FUSE_TICKS 120, frames from placement to detonation; EXPL_TICKS 30, frames the explosion is held; RANGE 2, blast reach in tiles per direction.
REQ-002 ADDR_W SHALL equal $clog2(NUM_ROW*NUM_COL), which is 8 at the defaults.
REQ-003 Ports SHALL be:
- clk  in  1  pixel clock; the block SHALL use one clock.
- rst  in  1  reset; synchronous and active-high.
- tick  in  1  one-cycle frame pulse.
- place_bomb  in  1  level request to drop a bomb.
- player_row  in  4  player tile row.
- player_col  in  5  player tile column.
- map_rd_addr  out  ADDR_W  tile read address.
- map_rd_data  in  DATA_WIDTH  tile read data, valid 1 cycle after the address.
- map_we  out  1  tile write strobe.
- map_wr_addr  out  ADDR_W  tile write address.
- map_wr_data  out  DATA_WIDTH  tile write data.
- bomb_active  out  1  high from bomb placement until the clear completes.
- expl_active  out  1  high during HOLD.

Function
REQ-004 Tile codes SHALL be FREE=0, SOLID=1, BREAK=2, BOMB=3, EXPL=4.
REQ-005 Tile address SHALL be row*NUM_COL+col, computed at ADDR_W width.
REQ-006 FSM states SHALL be IDLE, CHK_RD, CHK_EV, ARMED, SCAN_RD, SCAN_EV, HOLD, CLEAR.
REQ-007 IDLE: when place_bomb=1 the FSM SHALL latch the player address and go to CHK_RD.
REQ-008 CHK_RD SHALL drive map_rd_addr with the latched address for 1 cycle.
REQ-009 CHK_EV: if map_rd_data==FREE the block SHALL write BOMB to the latched address, load the fuse counter with FUSE_TICKS and go to ARMED; otherwise it SHALL return to IDLE with no write.
REQ-010 ARMED: the fuse counter SHALL decrement on each tick; on the tick that makes it 0 the block SHALL write EXPL to the centre tile, record the centre tile in the blast list, and go to SCAN_RD.
REQ-011 Scan order SHALL be up, down, left, right; distance 1..RANGE within each direction.
REQ-012 SCAN_RD SHALL drive the candidate address; SCAN_EV SHALL evaluate map_rd_data as follows:
- SOLID: stop the direction, no write.
- BREAK: write EXPL, record the tile, stop the direction.
- FREE, EXPL or BOMB: write EXPL, record the tile, continue the direction.
REQ-013 A candidate outside 0..NUM_ROW-1 or 0..NUM_COL-1 SHALL end its direction without a read; the row/column arithmetic SHALL be signed, with no wrap-around.
REQ-014 After the last direction the FSM SHALL load the hold counter with EXPL_TICKS and go to HOLD.
REQ-015 HOLD: the hold counter SHALL decrement on each tick; at 0 the FSM SHALL go to CLEAR.
REQ-016 CLEAR SHALL write FREE to every blast-list entry, one per cycle in recorded order, then clear the list and go to IDLE.
REQ-017 The blast list SHALL hold 1+4*RANGE addresses, and its count SHALL never exceed that depth.
REQ-018 map_we SHALL be a single-cycle strobe, asserted only in CHK_EV, ARMED (detonation cycle), SCAN_EV and CLEAR; map_wr_addr and map_wr_data SHALL be valid in the same cycle.
REQ-019 place_bomb SHALL be ignored in every state except IDLE, so there is at most one bomb at a time.
REQ-020 A tick coincident with acceptance of place_bomb SHALL NOT decrement the fuse counter.
REQ-021 Ticks arriving during CHK_*, SCAN_* or CLEAR SHALL be ignored.
REQ-022 bomb_active SHALL be high in every state except IDLE, CHK_RD and CHK_EV.

Reset
REQ-023 While rst=1 the block SHALL set state to IDLE, clear both counters and set the list count to 0.
REQ-024 While rst=1 the outputs SHALL be map_we=0, map_rd_addr=0, map_wr_addr=0, map_wr_data=0, bomb_active=0, expl_active=0.
REQ-025 A reset mid-operation SHALL abandon all pending clear writes; restoring the map is the map memory's reset responsibility.

Structure
REQ-026 A shared package SHALL hold the tile-code enum, NUM_ROW, NUM_COL and the address-width function; drawcon and the map logic SHALL import it.
REQ-027 The blast list SHALL be a sub-module, blast_list, providing push, pop-iterate, clear and count.
REQ-028 The map read port SHALL be a dedicated second read port of the tile map memory; this block SHALL NOT share drawcon's read port.

Verification
REQ-029 Placement on a free tile: player (5,9), tile FREE, place_bomb -> one write of addr 104 with data 3; bomb_active=1.
REQ-030 Placement on a solid tile: player tile SOLID -> no map_we; FSM back in IDLE after 2 cycles.
REQ-031 Fuse: 120 ticks after placement -> EXPL written to 104, followed by the scan writes.
REQ-032 Blocked scan: BREAK at (4,9), SOLID at (5,10) -> (4,9) written EXPL, (3,9) not read, right direction has zero writes.
REQ-033 Edge bomb: bomb at (1,1), RANGE 2 -> no reads with row<0 or col<0.
REQ-034 Clear: 30 ticks after the hold starts -> FREE written to every listed address in order; second place_bomb during HOLD ignored; rst asserted mid-CLEAR -> no further writes.

Source files
------------

// File: rtl/bomb_map_writer_pkg.sv
// rtl/bomb_map_writer_pkg.sv - shared tile codes, map geometry and FSM states for the bomb map writer
package bomb_map_writer_pkg;

  localparam int NUM_ROW = 11;
  localparam int NUM_COL = 19;

  typedef enum logic [3:0] {
    TILE_FREE  = 4'd0,
    TILE_SOLID = 4'd1,
    TILE_BREAK = 4'd2,
    TILE_BOMB  = 4'd3,
    TILE_EXPL  = 4'd4
  } tile_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK_RD,
    ST_CHK_EV,
    ST_ARMED,
    ST_SCAN_RD,
    ST_SCAN_EV,
    ST_HOLD,
    ST_CLEAR
  } state_e;

  function automatic int addr_width(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/blast_list.sv
// rtl/blast_list.sv - ordered list of tiles touched by one explosion, replayed once for the clear pass
module blast_list #(
  parameter int DEPTH  = 9,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic              pop_i,
  input  logic              clear_i,
  output logic [ADDR_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      idx_q   <= '0;
    end else if (clear_i) begin
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      // Pushes beyond the depth are dropped so the count can never overrun.
      if (push_i && (count_q < CNT_W'(DEPTH))) begin
        mem_q[count_q] <= push_addr_i;
        count_q        <= count_q + 1'b1;
      end
      if (pop_i && (idx_q < count_q)) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign head_o  = (idx_q < CNT_W'(DEPTH)) ? mem_q[idx_q] : '0;
  assign count_o = count_q;
  assign last_o  = (count_q != '0) && (idx_q == count_q - 1'b1);

endmodule

// File: rtl/bomb_map_writer.sv
// rtl/bomb_map_writer.sv - places one bomb, runs its fuse, paints the blast cross and clears it afterwards
module bomb_map_writer
  import bomb_map_writer_pkg::*;
#(
  parameter int NUM_ROW    = bomb_map_writer_pkg::NUM_ROW,
  parameter int NUM_COL    = bomb_map_writer_pkg::NUM_COL,
  parameter int DATA_WIDTH = 4,
  parameter int FUSE_TICKS = 120,
  parameter int EXPL_TICKS = 30,
  parameter int RANGE      = 2,
  parameter int ADDR_W     = addr_width(NUM_ROW, NUM_COL)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  place_bomb,
  input  logic [3:0]            player_row,
  input  logic [4:0]            player_col,
  output logic [ADDR_W-1:0]     map_rd_addr,
  input  logic [DATA_WIDTH-1:0] map_rd_data,
  output logic                  map_we,
  output logic [ADDR_W-1:0]     map_wr_addr,
  output logic [DATA_WIDTH-1:0] map_wr_data,
  output logic                  bomb_active,
  output logic                  expl_active
);

  localparam int FUSE_W     = $clog2(FUSE_TICKS + 1);
  localparam int HOLD_W     = $clog2(EXPL_TICKS + 1);
  localparam int DIST_W     = $clog2(RANGE + 1);
  localparam int LIST_DEPTH = 1 + 4 * RANGE;
  localparam int CNT_W      = $clog2(LIST_DEPTH + 1);

  state_e              state_q, state_d;
  logic [3:0]          row_q, row_d;
  logic [4:0]          col_q, col_d;
  logic [FUSE_W-1:0]   fuse_q, fuse_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [1:0]          dir_q, dir_d;
  logic [DIST_W-1:0]   dist_q, dist_d;

  int                  cand_r, cand_c;
  logic                cand_ok;
  logic [ADDR_W-1:0]   cand_addr, center_addr;

  logic [ADDR_W-1:0]     rd_addr, wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  we, next_dir;
  logic                  list_push, list_pop, list_clear, list_last;
  logic [ADDR_W-1:0]     list_push_addr, list_head;
  logic [CNT_W-1:0]      list_count;

  blast_list #(
    .DEPTH (LIST_DEPTH),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_blast_list (
    .clk        (clk),
    .rst        (rst),
    .push_i     (list_push),
    .push_addr_i(list_push_addr),
    .pop_i      (list_pop),
    .clear_i    (list_clear),
    .head_o     (list_head),
    .count_o    (list_count),
    .last_o     (list_last)
  );

  // Signed candidate coordinates so a step off the top/left edge goes negative instead of wrapping.
  always_comb begin
    cand_r = int'(row_q);
    cand_c = int'(col_q);
    case (dir_q)
      2'd0:    cand_r = cand_r - int'(dist_q);
      2'd1:    cand_r = cand_r + int'(dist_q);
      2'd2:    cand_c = cand_c - int'(dist_q);
      default: cand_c = cand_c + int'(dist_q);
    endcase
    cand_ok     = (cand_r >= 0) && (cand_r < NUM_ROW) && (cand_c >= 0) && (cand_c < NUM_COL);
    cand_addr   = ADDR_W'(cand_r * NUM_COL + cand_c);
    center_addr = ADDR_W'(int'(row_q) * NUM_COL + int'(col_q));
  end

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    col_d          = col_q;
    fuse_d         = fuse_q;
    hold_d         = hold_q;
    dir_d          = dir_q;
    dist_d         = dist_q;
    rd_addr        = '0;
    we             = 1'b0;
    wr_addr        = '0;
    wr_data        = '0;
    next_dir       = 1'b0;
    list_push      = 1'b0;
    list_push_addr = '0;
    list_pop       = 1'b0;
    list_clear     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (place_bomb) begin
          row_d   = player_row;
          col_d   = player_col;
          state_d = ST_CHK_RD;
        end
      end
      ST_CHK_RD: begin
        rd_addr = center_addr;
        state_d = ST_CHK_EV;
      end
      ST_CHK_EV: begin
        rd_addr = center_addr;
        if (map_rd_data == DATA_WIDTH'(TILE_FREE)) begin
          we      = 1'b1;
          wr_addr = center_addr;
          wr_data = DATA_WIDTH'(TILE_BOMB);
          fuse_d  = FUSE_W'(FUSE_TICKS);
          state_d = ST_ARMED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (tick) begin
          if (fuse_q <= FUSE_W'(1)) begin
            fuse_d         = '0;
            we             = 1'b1;
            wr_addr        = center_addr;
            wr_data        = DATA_WIDTH'(TILE_EXPL);
            list_push      = 1'b1;
            list_push_addr = center_addr;
            dir_d          = 2'd0;
            dist_d         = DIST_W'(1);
            state_d        = ST_SCAN_RD;
          end else begin
            fuse_d = fuse_q - 1'b1;
          end
        end
      end
      ST_SCAN_RD: begin
        if (cand_ok) begin
          rd_addr = cand_addr;
          state_d = ST_SCAN_EV;
        end else begin
          next_dir = 1'b1;
        end
      end
      ST_SCAN_EV: begin
        rd_addr = cand_addr;
        if (map_rd_data == DATA_WIDTH'(TILE_SOLID)) begin
          next_dir = 1'b1;
        end else begin
          we             = 1'b1;
          wr_addr        = cand_addr;
          wr_data        = DATA_WIDTH'(TILE_EXPL);
          list_push      = 1'b1;
          list_push_addr = cand_addr;
          if ((map_rd_data == DATA_WIDTH'(TILE_BREAK)) || (dist_q == DIST_W'(RANGE))) begin
            next_dir = 1'b1;
          end else begin
            dist_d  = dist_q + 1'b1;
            state_d = ST_SCAN_RD;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (hold_q <= HOLD_W'(1)) begin
            hold_d  = '0;
            state_d = ST_CLEAR;
          end else begin
            hold_d = hold_q - 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (list_count == '0) begin
          state_d = ST_IDLE;
        end else begin
          we       = 1'b1;
          wr_addr  = list_head;
          wr_data  = DATA_WIDTH'(TILE_FREE);
          list_pop = 1'b1;
          if (list_last) begin
            list_clear = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (next_dir) begin
      if (dir_q == 2'd3) begin
        hold_d  = HOLD_W'(EXPL_TICKS);
        state_d = ST_HOLD;
      end else begin
        dir_d   = dir_q + 2'd1;
        dist_d  = DIST_W'(1);
        state_d = ST_SCAN_RD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      fuse_q  <= '0;
      hold_q  <= '0;
      dir_q   <= '0;
      dist_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      fuse_q  <= fuse_d;
      hold_q  <= hold_d;
      dir_q   <= dir_d;
      dist_q  <= dist_d;
    end
  end

  assign map_rd_addr = rst ? '0 : rd_addr;
  assign map_we      = we & ~rst;
  assign map_wr_addr = rst ? '0 : wr_addr;
  assign map_wr_data = rst ? '0 : wr_data;
  assign bomb_active = ~rst & ~((state_q == ST_IDLE) || (state_q == ST_CHK_RD) || (state_q == ST_CHK_EV));
  assign expl_active = ~rst & (state_q == ST_HOLD);

endmodule

// File: tb/tb_bomb_map_writer.sv
// tb/tb_bomb_map_writer.sv - randomized self-checking bench for bomb_map_writer against a blast-cross model
module tb_bomb_map_writer;

  localparam int ROWS  = 11;
  localparam int COLS  = 19;
  localparam int TILES = ROWS * COLS;
  localparam int RNG   = 2;
  localparam int T_FREE = 0, T_SOLID = 1, T_BREAK = 2, T_BOMB = 3, T_EXPL = 4;

  logic       clk = 1'b0;
  logic       rst, tick, place_bomb;
  logic [3:0] player_row;
  logic [4:0] player_col;
  logic [7:0] map_rd_addr, map_wr_addr;
  logic [3:0] map_rd_data, map_wr_data;
  logic       map_we, bomb_active, expl_active;

  always #5 clk = ~clk;

  bomb_map_writer dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .place_bomb (place_bomb),
    .player_row (player_row),
    .player_col (player_col),
    .map_rd_addr(map_rd_addr),
    .map_rd_data(map_rd_data),
    .map_we     (map_we),
    .map_wr_addr(map_wr_addr),
    .map_wr_data(map_wr_data),
    .bomb_active(bomb_active),
    .expl_active(expl_active)
  );

  logic [3:0]  mem [0:255];
  logic [3:0]  img [0:255];
  logic        load_en = 1'b0;
  int          ref_map [ROWS][COLS];
  logic [11:0] wlog [$];
  logic [7:0]  rlog [$];
  int          exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Tile memory with the DUT's dedicated read port: one cycle of read latency.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (map_we) begin
      mem[map_wr_addr] <= map_wr_data;
    end
    map_rd_data <= mem[map_rd_addr];
  end

  always @(negedge clk) begin
    if (map_we) wlog.push_back({map_wr_addr, map_wr_data});
    if (bomb_active && !expl_active) rlog.push_back(map_rd_addr);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int taddr(input int r, input int c);
    return r * COLS + c;
  endfunction

  task automatic fill_map(input bit random_tiles);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        int v;
        v = $urandom_range(0, 9);
        ref_map[r][c] = !random_tiles ? T_FREE : (v < 6) ? T_FREE : (v < 8) ? T_SOLID : T_BREAK;
      end
  endtask

  task automatic load_map();
    for (int i = 0; i < 256; i++) img[i] = 4'd0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) img[taddr(r, c)] = 4'(ref_map[r][c]);
    load_en = 1'b1;
    step(1);
    load_en = 1'b0;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step($urandom_range(0, 2));
  endtask

  // Blast cross from the rules: centre first, then up/down/left/right out to RNG tiles.
  task automatic model_blast(input int br, input int bc);
    int dr[4] = '{-1, 1, 0, 0};
    int dc[4] = '{0, 0, -1, 1};
    exp_q.delete();
    exp_q.push_back(taddr(br, bc));
    for (int d = 0; d < 4; d++) begin
      for (int k = 1; k <= RNG; k++) begin
        int r, c;
        r = br + dr[d] * k;
        c = bc + dc[d] * k;
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) break;
        if (ref_map[r][c] == T_SOLID) break;
        exp_q.push_back(taddr(r, c));
        if (ref_map[r][c] == T_BREAK) break;
      end
    end
  endtask

  task automatic place(input int br, input int bc);
    player_row = 4'(br);
    player_col = 5'(bc);
    place_bomb = 1'b1;
    tick       = 1'b1;
    step(1);
    place_bomb = 1'b0;
    tick       = 1'b0;
  endtask

  task automatic run_bomb(input int br, input int bc, input bit rst_mid);
    int base, nw, oob, diffs;
    model_blast(br, bc);
    wlog.delete();
    rlog.delete();
    place(br, bc);
    step(3);
    check("place_writes", wlog.size(), 1);
    if (wlog.size() > 0) check("place_entry", int'(wlog[0]), (taddr(br, bc) << 4) | T_BOMB);
    check("armed_bomb_active", int'(bomb_active), 1);
    check("armed_expl_active", int'(expl_active), 0);
    for (int i = 1; i < 120; i++) begin
      place_bomb = ($urandom_range(0, 7) == 0);
      tick_pulse();
    end
    place_bomb = 1'b0;
    check("fuse_no_early_write", wlog.size(), 1);
    tick = 1'b1;
    step(1);
    step(1);
    tick = 1'b0;
    step(30);
    check("hold_expl_active", int'(expl_active), 1);
    check("scan_write_count", wlog.size(), 1 + exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (1 + i < wlog.size()) check("scan_entry", int'(wlog[1 + i]), (exp_q[i] << 4) | T_EXPL);
    oob = 0;
    foreach (rlog[i]) if (int'(rlog[i]) >= TILES) oob++;
    check("scan_reads_in_map", oob, 0);
    base = wlog.size();
    for (int i = 1; i < 30; i++) begin
      place_bomb = ($urandom_range(0, 3) == 0);
      tick_pulse();
    end
    place_bomb = 1'b0;
    check("hold_still_active", int'(expl_active), 1);
    check("hold_no_writes", wlog.size(), base);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    if (rst_mid) begin
      step(2);
      rst = 1'b1;
      nw  = wlog.size();
      check("clear_before_rst", nw, base + 2);
      #2;
      check("rst_we", int'(map_we), 0);
      check("rst_bomb_active", int'(bomb_active), 0);
      check("rst_rd_addr", int'(map_rd_addr), 0);
      step(5);
      check("rst_no_more_writes", wlog.size(), nw);
      check("rst_expl_active", int'(expl_active), 0);
      rst = 1'b0;
      step(2);
      check("post_rst_idle", int'(bomb_active), 0);
    end else begin
      step(exp_q.size() + 5);
      check("clear_write_count", wlog.size(), base + exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
        if (base + i < wlog.size()) check("clear_entry", int'(wlog[base + i]), (exp_q[i] << 4) | T_FREE);
      check("done_bomb_active", int'(bomb_active), 0);
      check("done_expl_active", int'(expl_active), 0);
      foreach (exp_q[i]) ref_map[exp_q[i] / COLS][exp_q[i] % COLS] = T_FREE;
      diffs = 0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (int'(mem[taddr(r, c)]) != ref_map[r][c]) diffs++;
      check("map_after_clear", diffs, 0);
    end
  endtask

  initial begin
    int hits, r, c;
    rst = 1'b1;
    tick = 1'b0;
    place_bomb = 1'b0;
    player_row = '0;
    player_col = '0;
    fill_map(1'b0);
    load_map();
    place_bomb = 1'b1;
    tick = 1'b1;
    step(3);
    check("reset_we", int'(map_we), 0);
    check("reset_rd_addr", int'(map_rd_addr), 0);
    check("reset_wr_addr", int'(map_wr_addr), 0);
    check("reset_wr_data", int'(map_wr_data), 0);
    check("reset_bomb_active", int'(bomb_active), 0);
    check("reset_expl_active", int'(expl_active), 0);
    place_bomb = 1'b0;
    tick = 1'b0;
    rst = 1'b0;
    step(2);
    check("idle_bomb_active", int'(bomb_active), 0);

    fill_map(1'b0);
    load_map();
    run_bomb(5, 9, 1'b0);

    ref_map[5][9] = T_SOLID;
    load_map();
    wlog.delete();
    place(5, 9);
    step(1);
    check("solid_bomb_active", int'(bomb_active), 0);
    step(3);
    check("solid_no_write", wlog.size(), 0);

    fill_map(1'b0);
    ref_map[4][9]  = T_BREAK;
    ref_map[5][10] = T_SOLID;
    load_map();
    run_bomb(5, 9, 1'b0);
    hits = 0;
    foreach (rlog[i]) if (int'(rlog[i]) == taddr(3, 9) || int'(rlog[i]) == taddr(5, 11)) hits++;
    check("blocked_not_read", hits, 0);

    fill_map(1'b0);
    load_map();
    run_bomb(1, 1, 1'b0);

    for (int n = 0; n < 5; n++) begin
      fill_map(1'b1);
      r = $urandom_range(0, ROWS - 1);
      c = $urandom_range(0, COLS - 1);
      ref_map[r][c] = T_FREE;
      load_map();
      run_bomb(r, c, 1'b0);
    end

    fill_map(1'b0);
    load_map();
    run_bomb(5, 9, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
